// File: rtl/ctl_ammo.sv
// ctl_ammo: ammunition / reload controller for the player's gun.
// Gates shot_fired into shot_accepted, enforces an inter-shot cooldown and a
// timed reload, and presents remaining ammo as two BCD digits.
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   shot_fired        1-cycle shot pulse from ctl_trigger
//   reload_req        1-cycle reload request (new round or manual reload)
//   pause             level; freezes timers and ignores shots and reloads
//   shot_accepted     1-cycle pulse when a shot consumed a round
//   ammo_ones/tens    BCD digits of remaining ammo
//   ammo_empty        remaining ammo == 0
//   reloading         high while in RELOAD
//   fire_enable       high only in READY with pause low
module ctl_ammo #(
  parameter int unsigned AMMO_MAX     = 12,
  parameter int unsigned COOLDOWN_CYC = 6_500_000,
  parameter int unsigned RELOAD_CYC   = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shot_fired,
  input  logic       reload_req,
  input  logic       pause,
  output logic       shot_accepted,
  output logic [3:0] ammo_ones,
  output logic [3:0] ammo_tens,
  output logic       ammo_empty,
  output logic       reloading,
  output logic       fire_enable
);

  localparam int unsigned TMAX = (COOLDOWN_CYC > RELOAD_CYC) ? COOLDOWN_CYC : RELOAD_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  // Reject illegal parameter sets at elaboration
  if (AMMO_MAX == 0 || AMMO_MAX > 99 || COOLDOWN_CYC == 0 || RELOAD_CYC == 0) begin : g_bad_param
    $error("ctl_ammo: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_COOLDOWN = 2'd1,
    S_EMPTY    = 2'd2,
    S_RELOAD   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     ones_q, ones_d;
  logic [3:0]     tens_q, tens_d;
  logic           shot_acc_q, shot_acc_d;
  logic           empty_q, empty_d;
  logic           reloading_q, reloading_d;
  logic           fire_en_q, fire_en_d;

  logic go_c;
  logic ammo_zero_c;
  logic ammo_one_c;
  logic fire_c;
  logic reload_c;

  assign go_c        = !pause;
  assign ammo_zero_c = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign ammo_one_c  = (tens_q == 4'd0) && (ones_q == 4'd1);
  // Reload has priority over a coincident shot
  assign reload_c    = go_c && reload_req;
  assign fire_c      = go_c && shot_fired && !reload_req && !ammo_zero_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_READY;
      timer_q     <= '0;
      ones_q      <= 4'(AMMO_MAX % 10);
      tens_q      <= 4'(AMMO_MAX / 10);
      shot_acc_q  <= 1'b0;
      empty_q     <= 1'b0;
      reloading_q <= 1'b0;
      fire_en_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      shot_acc_q  <= shot_acc_d;
      empty_q     <= empty_d;
      reloading_q <= reloading_d;
      fire_en_q   <= fire_en_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READY: begin
        if (reload_c)    state_d = S_RELOAD;
        else if (fire_c) state_d = ammo_one_c ? S_EMPTY : S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (reload_c)                        state_d = S_RELOAD;
        else if (go_c && timer_q == '0)      state_d = S_READY;
      end
      S_EMPTY: begin
        if (reload_c) state_d = S_RELOAD;
      end
      S_RELOAD: begin
        if (go_c && timer_q == '0) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    timer_d    = timer_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    shot_acc_d = 1'b0;
    case (state_q)
      S_READY: begin
        if (fire_c) begin
          shot_acc_d = 1'b1;
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
          timer_d = TW'(COOLDOWN_CYC - 1);
        end
      end
      S_COOLDOWN: begin
        if (go_c && timer_q != '0) timer_d = timer_q - TW'(1);
      end
      S_RELOAD: begin
        if (go_c) begin
          if (timer_q == '0) begin
            ones_d = 4'(AMMO_MAX % 10);
            tens_d = 4'(AMMO_MAX / 10);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      default: ;
    endcase
    // Entering RELOAD always starts a fresh reload period
    if (state_q != S_RELOAD && state_d == S_RELOAD) timer_d = TW'(RELOAD_CYC - 1);
    empty_d     = (ones_d == 4'd0) && (tens_d == 4'd0);
    reloading_d = (state_d == S_RELOAD);
    fire_en_d   = (state_d == S_READY) && go_c;
  end

  assign shot_accepted = shot_acc_q;
  assign ammo_ones     = ones_q;
  assign ammo_tens     = tens_q;
  assign ammo_empty    = empty_q;
  assign reloading     = reloading_q;
  assign fire_enable   = fire_en_q;

endmodule

// File: tb/tb_ctl_ammo.sv
// Directed self-checking bench for ctl_ammo (small-magazine and 12-round instances).
module tb_ctl_ammo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shot_fired = 1'b0;
  logic       shot12 = 1'b0;
  logic       reload_req = 1'b0;
  logic       pause = 1'b0;
  logic       shot_accepted, ammo_empty, reloading, fire_enable;
  logic [3:0] ammo_ones, ammo_tens;
  logic       sa12, empty12, rel12, fe12;
  logic [3:0] ones12, tens12;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctl_ammo #(.AMMO_MAX(3), .COOLDOWN_CYC(4), .RELOAD_CYC(8)) u_dut (
    .clk(clk), .rst(rst), .shot_fired(shot_fired), .reload_req(reload_req), .pause(pause),
    .shot_accepted(shot_accepted), .ammo_ones(ammo_ones), .ammo_tens(ammo_tens),
    .ammo_empty(ammo_empty), .reloading(reloading), .fire_enable(fire_enable));

  ctl_ammo #(.AMMO_MAX(12), .COOLDOWN_CYC(4), .RELOAD_CYC(8)) u_dut12 (
    .clk(clk), .rst(rst), .shot_fired(shot12), .reload_req(reload_req), .pause(pause),
    .shot_accepted(sa12), .ammo_ones(ones12), .ammo_tens(tens12),
    .ammo_empty(empty12), .reloading(rel12), .fire_enable(fe12));

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_shot();
    shot_fired = 1'b1;
    tick();
    shot_fired = 1'b0;
  endtask

  task automatic pulse_reload();
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (ammo_ones !== 4'd3) begin errors++; $display("FAIL reset_held_ones: got %0d expected 3", ammo_ones); end
    rst = 1'b1;
    tick();
    checks++; if (ammo_ones !== 4'd3) begin errors++; $display("FAIL reset_ones: got %0d expected 3", ammo_ones); end
    checks++; if (ammo_tens !== 4'd0) begin errors++; $display("FAIL reset_tens: got %0d expected 0", ammo_tens); end
    checks++; if (fire_enable !== 1'b1) begin errors++; $display("FAIL reset_fire_enable: got %b expected 1", fire_enable); end
    checks++; if (ammo_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b expected 0", ammo_empty); end
    checks++; if (reloading !== 1'b0) begin errors++; $display("FAIL reset_reloading: got %b expected 0", reloading); end
    checks++; if (shot_accepted !== 1'b0) begin errors++; $display("FAIL reset_shot_acc: got %b expected 0", shot_accepted); end
  endtask

  task automatic test_three_shots();
    logic [3:0] exp_ones;
    for (int k = 0; k < 3; k++) begin
      exp_ones = 4'(2 - k);
      pulse_shot();
      checks++; if (shot_accepted !== 1'b1) begin errors++; $display("FAIL shot%0d_acc: got %b expected 1", k, shot_accepted); end
      checks++; if (ammo_ones !== exp_ones) begin errors++; $display("FAIL shot%0d_ones: got %0d expected %0d", k, ammo_ones, exp_ones); end
      checks++; if (ammo_empty !== (k == 2)) begin errors++; $display("FAIL shot%0d_empty: got %b expected %b", k, ammo_empty, (k == 2)); end
      tick();
      checks++; if (shot_accepted !== 1'b0) begin errors++; $display("FAIL shot%0d_acc_width: got %b expected 0", k, shot_accepted); end
      repeat (4) tick();
    end
    pulse_shot();
    checks++; if (shot_accepted !== 1'b0) begin errors++; $display("FAIL dry_fire_acc: got %b expected 0", shot_accepted); end
    checks++; if (ammo_ones !== 4'd0) begin errors++; $display("FAIL dry_fire_ones: got %0d expected 0", ammo_ones); end
    checks++; if (fire_enable !== 1'b0) begin errors++; $display("FAIL empty_fire_enable: got %b expected 0", fire_enable); end
    checks++; if (ammo_empty !== 1'b1) begin errors++; $display("FAIL dry_fire_empty: got %b expected 1", ammo_empty); end
  endtask

  task automatic test_reload();
    pulse_reload();
    checks++; if (reloading !== 1'b1) begin errors++; $display("FAIL reload_start: got %b expected 1", reloading); end
    checks++; if (ammo_ones !== 4'd0) begin errors++; $display("FAIL reload_start_ones: got %0d expected 0", ammo_ones); end
    for (int i = 1; i < 8; i++) begin
      // Second request mid-reload must not restart the period
      if (i == 3) reload_req = 1'b1;
      tick();
      reload_req = 1'b0;
      checks++; if (ammo_ones !== 4'd0 || reloading !== 1'b1) begin errors++; $display("FAIL reload_hold_%0d: got ones=%0d rel=%b expected ones=0 rel=1", i, ammo_ones, reloading); end
    end
    tick();
    checks++; if (ammo_ones !== 4'd3) begin errors++; $display("FAIL refill_ones: got %0d expected 3", ammo_ones); end
    checks++; if (reloading !== 1'b0) begin errors++; $display("FAIL refill_reloading: got %b expected 0", reloading); end
    checks++; if (fire_enable !== 1'b1) begin errors++; $display("FAIL refill_fire_enable: got %b expected 1", fire_enable); end
    checks++; if (ammo_empty !== 1'b0) begin errors++; $display("FAIL refill_empty: got %b expected 0", ammo_empty); end
  endtask

  task automatic test_cooldown();
    pulse_shot();
    checks++; if (shot_accepted !== 1'b1 || ammo_ones !== 4'd2) begin errors++; $display("FAIL cd_first: got acc=%b ones=%0d expected acc=1 ones=2", shot_accepted, ammo_ones); end
    tick();
    pulse_shot();
    checks++; if (shot_accepted !== 1'b0 || ammo_ones !== 4'd2) begin errors++; $display("FAIL cd_blocked: got acc=%b ones=%0d expected acc=0 ones=2", shot_accepted, ammo_ones); end
    tick();
    checks++; if (fire_enable !== 1'b0) begin errors++; $display("FAIL cd_fire_enable_low: got %b expected 0", fire_enable); end
    tick();
    checks++; if (fire_enable !== 1'b1) begin errors++; $display("FAIL cd_fire_enable_back: got %b expected 1", fire_enable); end
    pulse_shot();
    checks++; if (shot_accepted !== 1'b1 || ammo_ones !== 4'd1) begin errors++; $display("FAIL cd_after: got acc=%b ones=%0d expected acc=1 ones=1", shot_accepted, ammo_ones); end
    repeat (5) tick();
  endtask

  task automatic test_bcd_borrow();
    logic [3:0] exp_t [3];
    logic [3:0] exp_o [3];
    exp_t[0] = 4'd1; exp_o[0] = 4'd1;
    exp_t[1] = 4'd1; exp_o[1] = 4'd0;
    exp_t[2] = 4'd0; exp_o[2] = 4'd9;
    do_reset();
    checks++; if (tens12 !== 4'd1 || ones12 !== 4'd2) begin errors++; $display("FAIL bcd_reset: got %0d/%0d expected 1/2", tens12, ones12); end
    for (int k = 0; k < 3; k++) begin
      shot12 = 1'b1;
      tick();
      shot12 = 1'b0;
      checks++; if (sa12 !== 1'b1 || tens12 !== exp_t[k] || ones12 !== exp_o[k]) begin errors++; $display("FAIL bcd_shot%0d: got acc=%b %0d/%0d expected acc=1 %0d/%0d", k, sa12, tens12, ones12, exp_t[k], exp_o[k]); end
      repeat (5) tick();
    end
  endtask

  task automatic test_pause_and_priority();
    do_reset();
    pulse_shot();
    repeat (5) tick();
    pulse_reload();
    checks++; if (reloading !== 1'b1 || ammo_ones !== 4'd2) begin errors++; $display("FAIL pr_reload_start: got rel=%b ones=%0d expected rel=1 ones=2", reloading, ammo_ones); end
    tick();
    tick();
    pause = 1'b1;
    repeat (5) tick();
    checks++; if (reloading !== 1'b1 || fire_enable !== 1'b0) begin errors++; $display("FAIL pr_paused: got rel=%b fe=%b expected rel=1 fe=0", reloading, fire_enable); end
    pause = 1'b0;
    repeat (5) tick();
    checks++; if (ammo_ones !== 4'd2 || reloading !== 1'b1) begin errors++; $display("FAIL pr_delayed: got ones=%0d rel=%b expected ones=2 rel=1", ammo_ones, reloading); end
    tick();
    checks++; if (ammo_ones !== 4'd3 || reloading !== 1'b0) begin errors++; $display("FAIL pr_refill: got ones=%0d rel=%b expected ones=3 rel=0", ammo_ones, reloading); end
    // Shot during pause in READY is ignored and fire_enable drops
    pause = 1'b1;
    shot_fired = 1'b1;
    tick();
    shot_fired = 1'b0;
    checks++; if (shot_accepted !== 1'b0 || ammo_ones !== 4'd3 || fire_enable !== 1'b0) begin errors++; $display("FAIL pause_shot: got acc=%b ones=%0d fe=%b expected acc=0 ones=3 fe=0", shot_accepted, ammo_ones, fire_enable); end
    pause = 1'b0;
    tick();
    checks++; if (fire_enable !== 1'b1) begin errors++; $display("FAIL unpause_fe: got %b expected 1", fire_enable); end
    pulse_shot();
    repeat (5) tick();
    // Coincident shot and reload in READY: reload wins
    shot_fired = 1'b1;
    reload_req = 1'b1;
    tick();
    shot_fired = 1'b0;
    reload_req = 1'b0;
    checks++; if (shot_accepted !== 1'b0 || ammo_ones !== 4'd2 || reloading !== 1'b1) begin errors++; $display("FAIL both_req: got acc=%b ones=%0d rel=%b expected acc=0 ones=2 rel=1", shot_accepted, ammo_ones, reloading); end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (reloading !== 1'b0 || ammo_ones !== 4'd3 || fire_enable !== 1'b1) begin errors++; $display("FAIL mid_reload_rst: got rel=%b ones=%0d fe=%b expected rel=0 ones=3 fe=1", reloading, ammo_ones, fire_enable); end
    rst = 1'b1;
    repeat (9) tick();
    checks++; if (reloading !== 1'b0 || ammo_ones !== 4'd3) begin errors++; $display("FAIL post_rst_ready: got rel=%b ones=%0d expected rel=0 ones=3", reloading, ammo_ones); end
  endtask

  initial begin
    test_reset();
    test_three_shots();
    test_reload();
    test_cooldown();
    test_bcd_borrow();
    test_pause_and_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
